// File: rtl/ps2_tx_if.sv
// Request/ack handshake between a byte producer and the PS/2 device transmitter.
interface ps2_tx_if;
    logic       start;
    logic [7:0] data;
    logic       ready;
    logic       finish;
    logic       faild;

    modport master (output start, output data, input ready, input finish, input faild);
    modport slave  (input start, input data, output ready, output finish, output faild);
endinterface

// File: rtl/ps2_tx.sv
// Device-side PS/2 transmitter: sends one byte as an 11-bit open-drain frame,
// generating PS2_CLK itself from the 4x bit-phase clock.
module ps2_tx #(
    parameter int IDLE_CHECK  = 4,
    parameter int BUS_TIMEOUT = 20
) (
    input  logic    clock_quarter,
    input  logic    reset_n,
    ps2_tx_if.slave bus,
    inout  wire     PS2_CLK,
    inout  wire     PS2_DAT
);
    localparam int IW = $clog2(IDLE_CHECK + 1);
    localparam int WW = $clog2(BUS_TIMEOUT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [1:0]    ph_q, ph_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          clk_sync_q, dat_sync_q;

    logic in_frame;
    logic inhibit;
    logic bit_val;
    logic clk_low;
    logic dat_low;

    always_ff @(posedge clock_quarter) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            ph_q       <= '0;
            bit_idx_q  <= '0;
            idle_cnt_q <= '0;
            wait_cnt_q <= '0;
            clk_sync_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            ph_q       <= ph_d;
            bit_idx_q  <= bit_idx_d;
            idle_cnt_q <= idle_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            clk_sync_q <= PS2_CLK;
            dat_sync_q <= PS2_DAT;
        end
    end

    // The host may only hold the clock low while we have released it (ph==3 of the
    // previous bit), so a low sample at ph==0 means the host is inhibiting.
    always_comb begin
        in_frame = (state_q == S_START) || (state_q == S_DATA) ||
                   (state_q == S_PARITY) || (state_q == S_STOP);
        inhibit  = ((state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP)) &&
                   (ph_q == 2'd0) && !clk_sync_q;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        ph_d       = '0;
        bit_idx_d  = bit_idx_q;
        idle_cnt_d = idle_cnt_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                idle_cnt_d = '0;
                wait_cnt_d = '0;
                bit_idx_d  = '0;
                if (bus.start) begin
                    shift_d  = bus.data;
                    parity_d = ~^bus.data;
                    state_d  = S_WAIT_BUS;
                end
            end
            S_WAIT_BUS: begin
                if (clk_sync_q && dat_sync_q) begin
                    if (idle_cnt_q != '1) idle_cnt_d = idle_cnt_q + 1'b1;
                end else begin
                    idle_cnt_d = '0;
                end
                if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
                if (idle_cnt_d == IW'(IDLE_CHECK)) begin
                    state_d = S_START;
                end else if (wait_cnt_d > WW'(BUS_TIMEOUT)) begin
                    state_d = S_ABORT;
                end
            end
            S_START, S_DATA, S_PARITY, S_STOP: begin
                if (inhibit) begin
                    state_d = S_ABORT;
                end else begin
                    ph_d = ph_q + 1'b1;
                    if (ph_q == 2'd3) begin
                        case (state_q)
                            S_START:  state_d = S_DATA;
                            S_DATA: begin
                                shift_d   = {1'b0, shift_q[7:1]};
                                bit_idx_d = bit_idx_q + 1'b1;
                                if (bit_idx_q == 3'd7) state_d = S_PARITY;
                            end
                            S_PARITY: state_d = S_STOP;
                            default:  state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_DONE, S_ABORT: state_d = S_IDLE;
            default:         state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bit_val = 1'b1;
        case (state_q)
            S_START:  bit_val = 1'b0;
            S_DATA:   bit_val = shift_q[0];
            S_PARITY: bit_val = parity_q;
            default:  bit_val = 1'b1;
        endcase
        clk_low = in_frame && ((ph_q == 2'd1) || (ph_q == 2'd2));
        dat_low = in_frame && !bit_val && !inhibit;
    end

    assign PS2_CLK    = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT    = dat_low ? 1'b0 : 1'bz;
    assign bus.ready  = (state_q == S_IDLE);
    assign bus.finish = (state_q == S_DONE) || (state_q == S_ABORT);
    assign bus.faild  = (state_q == S_ABORT);
endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a bench-side host decodes frames on the
// pulled-up open-drain lines and can inhibit the clock.
module tb_ps2_tx;
    logic clock_quarter = 1'b0;
    logic reset_n       = 1'b0;
    logic host_clk_low  = 1'b0;
    wire  ps2_clk;
    wire  ps2_dat;
    int   checks   = 0;
    int   failures = 0;

    ps2_tx_if bus ();

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;

    ps2_tx dut (
        .clock_quarter (clock_quarter),
        .reset_n       (reset_n),
        .bus           (bus),
        .PS2_CLK       (ps2_clk),
        .PS2_DAT       (ps2_dat)
    );

    always #5 clock_quarter = ~clock_quarter;

    // Host-side decode: data is sampled on each falling PS2_CLK; stops at finish.
    task automatic capture(input int budget, output logic [10:0] bits, output int nlow,
                           output int bad_w, output int dlow, output bit fin,
                           output bit fl, output int ncyc);
        logic prev_clk;
        int   w;
        bits = '0; nlow = 0; bad_w = 0; dlow = 0; fin = 0; fl = 0; ncyc = 0;
        prev_clk = 1'b1; w = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock_quarter);
            ncyc = i + 1;
            if (ps2_dat == 1'b0) dlow++;
            if (ps2_clk == 1'b0) begin
                if (prev_clk == 1'b1) begin
                    if (nlow < 11) bits[nlow] = ps2_dat;
                    nlow++;
                    w = 0;
                end
                w++;
            end else if (prev_clk == 1'b0 && w != 2) begin
                bad_w++;
            end
            prev_clk = ps2_clk;
            if (bus.finish) begin
                fin = 1'b1;
                fl  = bus.faild;
                break;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] b, output logic [10:0] bits, output int nlow,
                             output int bad_w, output int dlow, output bit fin,
                             output bit fl, output int ncyc);
        @(posedge clock_quarter); #1;
        bus.start = 1'b1;
        bus.data  = b;
        @(posedge clock_quarter); #1;
        bus.start = 1'b0;
        capture(120, bits, nlow, bad_w, dlow, fin, fl, ncyc);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock_quarter);
        @(negedge clock_quarter);
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        checks++; if (bus.finish !== 1'b0) begin failures++; $display("FAIL reset_finish: got %b expected 0", bus.finish); end
        checks++; if (bus.faild !== 1'b0) begin failures++; $display("FAIL reset_faild: got %b expected 0", bus.faild); end
        checks++; if (ps2_clk !== 1'b1) begin failures++; $display("FAIL reset_clk_pin: got %b expected 1", ps2_clk); end
        checks++; if (ps2_dat !== 1'b1) begin failures++; $display("FAIL reset_dat_pin: got %b expected 1", ps2_dat); end
        reset_n = 1'b1;
    endtask

    task automatic test_frame_a5();
        logic [10:0] bits; int nlow, bad_w, dlow, ncyc; bit fin, fl;
        run_frame(8'hA5, bits, nlow, bad_w, dlow, fin, fl, ncyc);
        checks++; if (bits !== 11'h74A) begin failures++; $display("FAIL a5_bits: got %h expected 74a", bits); end
        checks++; if (nlow !== 11) begin failures++; $display("FAIL a5_clk_lows: got %0d expected 11", nlow); end
        checks++; if (bad_w !== 0) begin failures++; $display("FAIL a5_low_width: got %0d bad pulses expected 0", bad_w); end
        checks++; if (fin !== 1'b1) begin failures++; $display("FAIL a5_finish: got %b expected 1", fin); end
        checks++; if (fl !== 1'b0) begin failures++; $display("FAIL a5_faild: got %b expected 0", fl); end
        checks++; if (ncyc !== 49) begin failures++; $display("FAIL a5_latency: got %0d expected 49", ncyc); end
    endtask

    task automatic test_parity();
        logic [10:0] bits; int nlow, bad_w, dlow, ncyc; bit fin, fl;
        run_frame(8'h00, bits, nlow, bad_w, dlow, fin, fl, ncyc);
        checks++; if (bits !== 11'h600) begin failures++; $display("FAIL par00_bits: got %h expected 600", bits); end
        checks++; if ({fin, fl} !== 2'b10) begin failures++; $display("FAIL par00_done: got %b expected 10", {fin, fl}); end
        run_frame(8'h01, bits, nlow, bad_w, dlow, fin, fl, ncyc);
        checks++; if (bits !== 11'h402) begin failures++; $display("FAIL par01_bits: got %h expected 402", bits); end
        checks++; if (nlow !== 11) begin failures++; $display("FAIL par01_clk_lows: got %0d expected 11", nlow); end
    endtask

    task automatic test_bus_timeout();
        logic [10:0] bits; int nlow, bad_w, dlow, ncyc; bit fin, fl;
        host_clk_low = 1'b1;
        run_frame(8'h00, bits, nlow, bad_w, dlow, fin, fl, ncyc);
        checks++; if ({fin, fl} !== 2'b11) begin failures++; $display("FAIL timeout_abort: got %b expected 11", {fin, fl}); end
        checks++; if (ncyc !== 22) begin failures++; $display("FAIL timeout_cycle: got %0d expected 22", ncyc); end
        checks++; if (dlow !== 0) begin failures++; $display("FAIL timeout_dat_driven: got %0d low cycles expected 0", dlow); end
        repeat (8) @(negedge clock_quarter);
        host_clk_low = 1'b0;
        repeat (2) @(negedge clock_quarter);
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL timeout_ready: got %b expected 1", bus.ready); end
    endtask

    task automatic test_inhibit();
        int fin_at = 0;
        logic dat_at_ph0 = 1'b0;
        @(posedge clock_quarter); #1;
        bus.start = 1'b1;
        bus.data  = 8'hA5;
        @(posedge clock_quarter); #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock_quarter);
            if (i == 24) host_clk_low = 1'b1;
            if (i == 25) dat_at_ph0 = ps2_dat;
            if (bus.finish && fin_at == 0) begin
                fin_at = i;
                checks++; if (bus.faild !== 1'b1) begin failures++; $display("FAIL inhibit_faild: got %b expected 1", bus.faild); end
                break;
            end
        end
        checks++; if (fin_at !== 26) begin failures++; $display("FAIL inhibit_abort_cycle: got %0d expected 26", fin_at); end
        checks++; if (dat_at_ph0 !== 1'b1) begin failures++; $display("FAIL inhibit_dat_release: got %b expected 1", dat_at_ph0); end
        host_clk_low = 1'b0;
        repeat (2) @(negedge clock_quarter);
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits; int nlow, bad_w, dlow, ncyc; bit fin, fl;
        @(posedge clock_quarter); #1;
        bus.start = 1'b1;
        bus.data  = 8'h00;
        @(posedge clock_quarter); #1;
        bus.start = 1'b0;
        repeat (42) @(negedge clock_quarter);
        reset_n = 1'b0;
        @(negedge clock_quarter);
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL midreset_ready: got %b expected 1", bus.ready); end
        checks++; if ({ps2_clk, ps2_dat} !== 2'b11) begin failures++; $display("FAIL midreset_pins: got %b expected 11", {ps2_clk, ps2_dat}); end
        reset_n = 1'b1;
        run_frame(8'h81, bits, nlow, bad_w, dlow, fin, fl, ncyc);
        checks++; if (bits !== 11'h702) begin failures++; $display("FAIL midreset_frame: got %h expected 702", bits); end
        checks++; if ({fin, fl, nlow[4:0]} !== {2'b10, 5'd11}) begin failures++; $display("FAIL midreset_done: got fin=%b fl=%b lows=%0d expected 1 0 11", fin, fl, nlow); end
    endtask

    task automatic test_back_to_back();
        logic [21:0] bits = '0;
        int nlow = 0, nfin = 0, nfail = 0, hi = 0, gap = -1;
        logic prev_clk = 1'b1;
        bit changed = 1'b0;
        @(posedge clock_quarter); #1;
        bus.start = 1'b1;
        bus.data  = 8'hA5;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock_quarter);
            if (!bus.ready && !changed) begin
                bus.data = 8'h3C;
                changed  = 1'b1;
            end
            if (ps2_clk == 1'b0) begin
                if (prev_clk == 1'b1) begin
                    if (nlow == 11) gap = hi;
                    if (nlow < 22) bits[nlow] = ps2_dat;
                    nlow++;
                end
                hi = 0;
            end else begin
                hi++;
            end
            prev_clk = ps2_clk;
            if (bus.finish) begin
                nfin++;
                if (bus.faild) nfail++;
                if (nfin == 2) begin
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        checks++; if (bits !== {11'h678, 11'h74A}) begin failures++; $display("FAIL b2b_bits: got %h expected %h", bits, {11'h678, 11'h74A}); end
        checks++; if (nlow !== 22) begin failures++; $display("FAIL b2b_clk_lows: got %0d expected 22", nlow); end
        checks++; if (nfin !== 2 || nfail !== 0) begin failures++; $display("FAIL b2b_finish: got %0d finishes %0d faild expected 2 0", nfin, nfail); end
        checks++; if (gap < 4) begin failures++; $display("FAIL b2b_gap: got %0d idle cycles expected at least 4", gap); end
        repeat (3) @(negedge clock_quarter);
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after: got %b expected 1", bus.ready); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.data  = 8'h00;
        test_reset();
        test_frame_a5();
        test_parity();
        test_bus_timeout();
        test_inhibit();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
